// File: rtl/branch_predict_pkg.sv
// Shared types and helpers for the branch predictor.
//   sat_ctr_t      : 2-bit saturating counter
//   SAT_CTR_RESET  : weakly not-taken reset value
//   SAT_CTR_MAX    : strongly taken ceiling
//   sat_ctr_next() : one saturating training step, never wraps
package branch_predict_pkg;

   typedef logic [1:0] sat_ctr_t;

   localparam sat_ctr_t SAT_CTR_RESET = 2'b01;
   localparam sat_ctr_t SAT_CTR_MAX   = 2'b11;
   localparam sat_ctr_t SAT_CTR_MIN   = 2'b00;

   function automatic sat_ctr_t sat_ctr_next(sat_ctr_t c, logic taken);
      sat_ctr_t n;
      if (taken) begin
         n = (c == SAT_CTR_MAX) ? c : c + 2'b01;
      end else begin
         n = (c == SAT_CTR_MIN) ? c : c - 2'b01;
      end
      return n;
   endfunction

endpackage

// File: rtl/global_history_reg.sv
// Global branch history shift register with recovery-load priority.
// Ports:
//   clk, areset      : clock, synchronous active-high reset (history -> 0)
//   recover_valid    : misprediction recovery, wins over shift_valid
//   recover_low      : low HIST_W-1 bits of the history captured at predict time
//   recover_taken    : resolved outcome appended after recovery
//   shift_valid      : a prediction was issued; shift in shift_bit
//   shift_bit        : predicted direction
//   history          : current history (registered)
module global_history_reg
   import branch_predict_pkg::*;
#(
   parameter int unsigned HIST_W = 7
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              recover_valid,
   input  logic [HIST_W-2:0] recover_low,
   input  logic              recover_taken,
   input  logic              shift_valid,
   input  logic              shift_bit,
   output logic [HIST_W-1:0] history
);

   logic [HIST_W-1:0] history_d, history_q;

   always_comb begin
      history_d = history_q;
      if (recover_valid) begin
         history_d = {recover_low, recover_taken};
      end else if (shift_valid) begin
         history_d = {history_q[HIST_W-2:0], shift_bit};
      end
   end

   always_ff @(posedge clk) begin
      if (areset) begin
         history_q <= '0;
      end else begin
         history_q <= history_d;
      end
   end

   assign history = history_q;

endmodule

// File: rtl/branch_predict_gshare.sv
// gshare branch predictor: PHT of 2-bit counters indexed by PC ^ global history.
// Optional macro: GSHARE_BYPASS_EN forwards a same-index training write into the
// same-cycle prediction (and therefore into the history shift).
// Ports:
//   clk, areset          : clock, synchronous active-high reset
//   predict_valid        : fetch issued a prediction; gates the history shift
//   predict_pc           : PC being predicted
//   predict_taken        : predicted direction (combinational)
//   predict_history      : history used for this prediction (combinational)
//   train_valid          : resolved branch reported
//   train_taken          : actual outcome
//   train_mispredicted   : restore history from train_history
//   train_pc             : PC of resolved branch
//   train_history        : history captured at predict time
// HIST_W must equal PC_W.
module branch_predict_gshare
   import branch_predict_pkg::*;
#(
   parameter int unsigned PC_W   = 7,
   parameter int unsigned HIST_W = 7
) (
   input  logic              clk,
   input  logic              areset,
   input  logic              predict_valid,
   input  logic [PC_W-1:0]   predict_pc,
   output logic              predict_taken,
   output logic [HIST_W-1:0] predict_history,
   input  logic              train_valid,
   input  logic              train_taken,
   input  logic              train_mispredicted,
   input  logic [PC_W-1:0]   train_pc,
   input  logic [HIST_W-1:0] train_history
);

   localparam int unsigned DEPTH = 2 ** PC_W;

   sat_ctr_t          pht_q [DEPTH];
   logic [HIST_W-1:0] history;
   logic [PC_W-1:0]   pred_idx;
   logic [PC_W-1:0]   train_idx;
   sat_ctr_t          train_ctr_next;

   assign pred_idx       = predict_pc ^ history;
   assign train_idx      = train_pc ^ train_history;
   assign train_ctr_next = sat_ctr_next(pht_q[train_idx], train_taken);

   always_comb begin
      predict_taken = pht_q[pred_idx][1];
`ifdef GSHARE_BYPASS_EN
      if (train_valid && (train_idx == pred_idx)) begin
         predict_taken = train_ctr_next[1];
      end
`endif
   end

   assign predict_history = history;

   always_ff @(posedge clk) begin
      if (areset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            pht_q[i] <= SAT_CTR_RESET;
         end
      end else if (train_valid) begin
         pht_q[train_idx] <= train_ctr_next;
      end
   end

   global_history_reg #(
      .HIST_W(HIST_W)
   ) u_history (
      .clk          (clk),
      .areset       (areset),
      .recover_valid(train_valid && train_mispredicted),
      .recover_low  (train_history[HIST_W-2:0]),
      .recover_taken(train_taken),
      .shift_valid  (predict_valid),
      .shift_bit    (predict_taken),
      .history      (history)
   );

endmodule

// File: tb/tb_branch_predict_gshare.sv
module tb_branch_predict_gshare;

   logic       clk;
   logic       areset;
   logic       predict_valid;
   logic [6:0] predict_pc;
   logic       predict_taken;
   logic [6:0] predict_history;
   logic       train_valid;
   logic       train_taken;
   logic       train_mispredicted;
   logic [6:0] train_pc;
   logic [6:0] train_history;

   int checks = 0;
   int errors = 0;

   branch_predict_gshare dut (
      .clk               (clk),
      .areset            (areset),
      .predict_valid     (predict_valid),
      .predict_pc        (predict_pc),
      .predict_taken     (predict_taken),
      .predict_history   (predict_history),
      .train_valid       (train_valid),
      .train_taken       (train_taken),
      .train_mispredicted(train_mispredicted),
      .train_pc          (train_pc),
      .train_history     (train_history)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      predict_valid      = 1'b0;
      predict_pc         = '0;
      train_valid        = 1'b0;
      train_taken        = 1'b0;
      train_mispredicted = 1'b0;
      train_pc           = '0;
      train_history      = '0;
   endtask

   task automatic do_reset();
      idle();
      areset = 1'b1;
      cycle();
      cycle();
      areset = 1'b0;
   endtask

   // One correctly-predicted training step at index pc (history 0).
   task automatic train(input logic [6:0] pc, input logic taken);
      train_valid        = 1'b1;
      train_pc           = pc;
      train_history      = '0;
      train_taken        = taken;
      train_mispredicted = 1'b0;
      cycle();
      train_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [6:0] pcs [3];
      pcs[0] = 7'h00;
      pcs[1] = 7'h55;
      pcs[2] = 7'h7F;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         predict_pc = pcs[i];
         #1;
         checks++;
         if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_taken pc=%h: got %b want 0", pcs[i], predict_taken);
         end
      end
      checks++;
      if (predict_history !== 7'h00) begin
         errors++;
         $display("FAIL reset_history: got %h want 00", predict_history);
      end
   endtask

   task automatic test_saturate_up();
      logic exp [5];
      logic tk [5];
      // 01 ->T 10 ->T 11 ->T 11 ->N 10 ->N 01
      tk[0] = 1'b1; exp[0] = 1'b1;
      tk[1] = 1'b1; exp[1] = 1'b1;
      tk[2] = 1'b1; exp[2] = 1'b1;
      tk[3] = 1'b0; exp[3] = 1'b1;
      tk[4] = 1'b0; exp[4] = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         train(7'h05, tk[i]);
         predict_pc = 7'h05;
         #1;
         checks++;
         if (predict_taken !== exp[i]) begin
            errors++;
            $display("FAIL sat_up step%0d: got %b want %b", i, predict_taken, exp[i]);
         end
      end
   endtask

   task automatic test_saturate_down();
      do_reset();
      for (int i = 0; i < 4; i++) train(7'h10, 1'b0);
      predict_pc = 7'h10;
      #1;
      checks++;
      if (predict_taken !== 1'b0) begin
         errors++;
         $display("FAIL sat_down_floor: got %b want 0", predict_taken);
      end
      train(7'h10, 1'b1);  // 00 -> 01
      #1;
      checks++;
      if (predict_taken !== 1'b0) begin
         errors++;
         $display("FAIL sat_down_after_taken: got %b want 0", predict_taken);
      end
      train(7'h10, 1'b1);  // 01 -> 10
      #1;
      checks++;
      if (predict_taken !== 1'b1) begin
         errors++;
         $display("FAIL sat_down_second_taken: got %b want 1", predict_taken);
      end
   endtask

   task automatic test_recovery();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         predict_valid = 1'b1;
         predict_pc    = 7'h00;
         #1;
         checks++;
         if (predict_taken !== 1'b0 || predict_history !== 7'h00) begin
            errors++;
            $display("FAIL shift_zero%0d: got taken=%b hist=%h want 0/00", i, predict_taken,
                     predict_history);
         end
         cycle();
      end
      // Recovery in the same cycle as a prediction; train index 2A^2A = 0.
      predict_valid      = 1'b1;
      predict_pc         = 7'h00;
      train_valid        = 1'b1;
      train_mispredicted = 1'b1;
      train_history      = 7'h2A;
      train_pc           = 7'h2A;
      train_taken        = 1'b1;
      cycle();
      idle();
      #1;
      checks++;
      if (predict_history !== 7'h55) begin
         errors++;
         $display("FAIL recovery_wins: got %h want 55", predict_history);
      end
      // Correctly predicted train: PHT only.
      train_valid   = 1'b1;
      train_pc      = 7'h11;
      train_history = 7'h22;
      cycle();
      idle();
      #1;
      checks++;
      if (predict_history !== 7'h55) begin
         errors++;
         $display("FAIL correct_train_no_hist: got %h want 55", predict_history);
      end
      // train_valid low: mispredicted/history are ignored.
      train_mispredicted = 1'b1;
      train_history      = 7'h7F;
      train_taken        = 1'b1;
      cycle();
      idle();
      #1;
      checks++;
      if (predict_history !== 7'h55) begin
         errors++;
         $display("FAIL train_invalid_no_hist: got %h want 55", predict_history);
      end
      // pc 55 ^ hist 55 = index 0, now counter 10.
      predict_valid = 1'b1;
      predict_pc    = 7'h55;
      #1;
      checks++;
      if (predict_taken !== 1'b1) begin
         errors++;
         $display("FAIL predict_idx0: got %b want 1", predict_taken);
      end
      cycle();
      idle();
      #1;
      checks++;
      if (predict_history !== 7'h2B) begin
         errors++;
         $display("FAIL shift_one: got %h want 2b", predict_history);
      end
   endtask

   task automatic test_same_cycle();
      logic exp_now;
`ifdef GSHARE_BYPASS_EN
      exp_now = 1'b1;
`else
      exp_now = 1'b0;
`endif
      do_reset();
      predict_pc  = 7'h03;
      train_valid = 1'b1;
      train_pc    = 7'h03;
      train_taken = 1'b1;
      #1;
      checks++;
      if (predict_taken !== exp_now) begin
         errors++;
         $display("FAIL same_cycle_now: got %b want %b", predict_taken, exp_now);
      end
      cycle();
      train_valid = 1'b0;
      #1;
      checks++;
      if (predict_taken !== 1'b1) begin
         errors++;
         $display("FAIL same_cycle_next: got %b want 1", predict_taken);
      end
   endtask

   task automatic test_reset_mid();
      logic [6:0] pcs [3];
      pcs[0] = 7'h05;
      pcs[1] = 7'h10;
      pcs[2] = 7'h2A;
      do_reset();
      train(7'h05, 1'b1);
      train(7'h05, 1'b1);
      train_valid        = 1'b1;
      train_mispredicted = 1'b1;
      train_history      = 7'h2A;
      train_pc           = 7'h00;
      train_taken        = 1'b1;
      cycle();
      idle();
      // Reset with training and prediction active the same cycle.
      areset             = 1'b1;
      predict_valid      = 1'b1;
      predict_pc         = 7'h10;
      train_valid        = 1'b1;
      train_mispredicted = 1'b1;
      train_pc           = 7'h10;
      train_taken        = 1'b1;
      train_history      = 7'h00;
      cycle();
      areset = 1'b0;
      idle();
      #1;
      checks++;
      if (predict_history !== 7'h00) begin
         errors++;
         $display("FAIL mid_reset_history: got %h want 00", predict_history);
      end
      for (int i = 0; i < 3; i++) begin
         predict_pc = pcs[i];
         #1;
         checks++;
         if (predict_taken !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_taken pc=%h: got %b want 0", pcs[i], predict_taken);
         end
      end
      // One taken step from 01 must reach 10.
      train(7'h10, 1'b1);
      predict_pc = 7'h10;
      #1;
      checks++;
      if (predict_taken !== 1'b1) begin
         errors++;
         $display("FAIL mid_reset_weak: got %b want 1", predict_taken);
      end
   endtask

   initial begin
      areset = 1'b1;
      idle();
      test_reset();
      test_saturate_up();
      test_saturate_down();
      test_recovery();
      test_same_cycle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
